// File: rtl/ins_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ins_mem_loader                                                           |
// | Packs a byte stream little-endian into instruction words and writes them |
// | to consecutive instruction-memory addresses from 0, holding the core.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ins_mem_loader #(
    parameter  int INSTRUCTION_WIDTH = 32,
    parameter  int MEMORY_DEPTH      = 256,
    localparam int ADDRESS_WIDTH     = $clog2(MEMORY_DEPTH),
    localparam int BYTES_PER_WORD    = INSTRUCTION_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         start,
    input  logic [ADDRESS_WIDTH:0]       word_count,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         wr_en,
    output logic [ADDRESS_WIDTH-1:0]     wr_addr,
    output logic [INSTRUCTION_WIDTH-1:0] wr_data,
    output logic                         busy,
    output logic                         done
);

    localparam int BYTE_IDX_WIDTH = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [ADDRESS_WIDTH:0]    c_depth     = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);
    localparam logic [ADDRESS_WIDTH:0]    c_word_one  = (ADDRESS_WIDTH + 1)'(1);
    localparam logic [BYTE_IDX_WIDTH-1:0] c_byte_one  = BYTE_IDX_WIDTH'(1);
    localparam logic [BYTE_IDX_WIDTH-1:0] c_last_lane = BYTE_IDX_WIDTH'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                         r_state;
    logic [BYTE_IDX_WIDTH-1:0]      r_byte_idx;
    logic [ADDRESS_WIDTH:0]         r_word_idx;
    logic [ADDRESS_WIDTH:0]         r_count;
    logic [INSTRUCTION_WIDTH-1:0]   r_word;
    logic                           r_wr_en;
    logic [ADDRESS_WIDTH-1:0]       r_wr_addr;
    logic [INSTRUCTION_WIDTH-1:0]   r_wr_data;
    logic                           r_busy;
    logic                           r_done;

    logic [ADDRESS_WIDTH:0]         w_count_sat;
    logic                           w_final;
    logic                           w_accept;
    logic                           w_last_lane;
    logic [INSTRUCTION_WIDTH-1:0]   w_word;

    assign w_count_sat = (word_count > c_depth) ? c_depth : word_count;
    assign w_final     = (r_word_idx == r_count);
    // A byte seen during WRITE starts the next word, unless that write was the last one.
    assign w_accept    = rx_valid && ((r_state == RECEIVE) || ((r_state == WRITE) && !w_final));
    assign w_last_lane = (r_byte_idx == c_last_lane);

    always_comb begin
        w_word = r_word;
        w_word[8*int'(r_byte_idx) +: 8] = rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state    <= IDLE;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_count    <= w_count_sat;
                        r_byte_idx <= '0;
                        r_word_idx <= '0;
                        if (w_count_sat == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RECEIVE;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (w_final) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= RECEIVE;
                    end
                end
                default: begin
                end
            endcase

            // Byte capture overrides the next state when it completes a word.
            if (w_accept) begin
                r_word <= w_word;
                if (w_last_lane) begin
                    r_byte_idx <= '0;
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= r_word_idx[ADDRESS_WIDTH-1:0];
                    r_wr_data  <= w_word;
                    r_word_idx <= r_word_idx + c_word_one;
                    r_state    <= WRITE;
                end else begin
                    r_byte_idx <= r_byte_idx + c_byte_one;
                end
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ins_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ins_mem_loader                                                        |
// | Directed and random loads checked against a queue-based load model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ins_mem_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  word_count = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    ins_mem_loader #(.INSTRUCTION_WIDTH(32), .MEMORY_DEPTH(DEPTH)) dut (
        .clk(clk), .rstN(rstN), .start(start), .word_count(word_count),
        .rx_data(rx_data), .rx_valid(rx_valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: a load is "active" from an accepted start until count words are written.
    bit          m_active = 0, m_done = 0, m_wr = 0, m_prev_wr = 0;
    int          m_count = 0, m_widx = 0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [7:0]  m_q[$];
    int          n_wr = 0;
    logic [7:0]  last_addr = '0;
    logic [31:0] mem[DEPTH];

    always @(posedge clk) begin
        if (!rstN) begin
            m_active = 0; m_done = 0; m_wr = 0; m_addr = '0; m_data = '0;
            m_count = 0; m_widx = 0; m_q.delete();
        end else begin
            m_prev_wr = m_wr;
            m_wr = 0;
            if (!m_active) begin
                if (start) begin
                    m_count = (int'(word_count) > DEPTH) ? DEPTH : int'(word_count);
                    m_widx = 0;
                    m_q.delete();
                    if (m_count == 0) m_done = 1;
                    else begin m_active = 1; m_done = 0; end
                end
            end else if (m_prev_wr && m_widx == m_count) begin
                m_active = 0;
                m_done = 1;
            end else if (rx_valid) begin
                m_q.push_back(rx_data);
                if (m_q.size() == 4) begin
                    m_data = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_addr = 8'(m_widx);
                    m_widx++;
                    m_wr = 1;
                    m_q.delete();
                end
            end
        end
        #1;
        chk("wr_en", 64'(wr_en), 64'(m_wr));
        chk("busy", 64'(busy), 64'(m_active));
        chk("done", 64'(done), 64'(m_done));
        chk("wr_addr", 64'(wr_addr), 64'(m_addr));
        chk("wr_data", 64'(wr_data), 64'(m_data));
        if (wr_en === 1'b1) begin
            n_wr++;
            last_addr = wr_addr;
            mem[wr_addr] = wr_data;
        end
    end

    task automatic cyc(input logic s, input logic [8:0] wc, input logic v, input logic [7:0] d);
        @(negedge clk);
        start = s; word_count = wc; rx_valid = v; rx_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0, '0);
    endtask

    int n0;
    logic [7:0]  bytes1[8];
    logic [31:0] exp_w;

    initial begin
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        idle(2);

        // Two words with gaps between bytes.
        bytes1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        n0 = n_wr;
        cyc(1'b1, 9'd2, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, 1'b1, bytes1[i]);
            idle(i % 3);
        end
        idle(3);
        chk("gap_nwr", 64'(n_wr - n0), 64'd2);
        chk("gap_mem0", 64'(mem[0]), 64'h0000_0013);
        chk("gap_mem1", 64'(mem[1]), 64'h0010_0093);
        chk("gap_done", 64'(done), 64'd1);

        // Back-to-back bytes, four words.
        n0 = n_wr;
        cyc(1'b1, 9'd4, 1'b0, '0);
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1, 8'(i + 1));
        idle(3);
        chk("b2b_nwr", 64'(n_wr - n0), 64'd4);
        for (int j = 0; j < 4; j++) begin
            exp_w = {8'(4*j + 4), 8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1)};
            chk("b2b_mem", 64'(mem[j]), 64'(exp_w));
        end

        // Zero-word load.
        n0 = n_wr;
        cyc(1'b1, 9'd0, 1'b0, '0);
        idle(2);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_nwr", 64'(n_wr - n0), 64'd0);

        // Oversized count saturates at the memory depth.
        n0 = n_wr;
        cyc(1'b1, 9'd300, 1'b0, '0);
        for (int i = 0; i < 1210; i++) cyc(1'b0, '0, 1'b1, 8'($urandom));
        idle(3);
        chk("sat_nwr", 64'(n_wr - n0), 64'd256);
        chk("sat_last", 64'(last_addr), 64'd255);
        chk("sat_done", 64'(done), 64'd1);

        // Reset part-way through the first word.
        n0 = n_wr;
        cyc(1'b1, 9'd1, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 8'hAA);
        cyc(1'b0, '0, 1'b1, 8'hBB);
        @(negedge clk); rstN = 1'b0; rx_valid = 1'b0;
        @(negedge clk); rstN = 1'b1;
        chk("rst_nwr", 64'(n_wr - n0), 64'd0);
        cyc(1'b1, 9'd1, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 8'(8'hC1 + i));
        idle(2);
        chk("rst_mem0", 64'(mem[0]), 64'hC4C3_C2C1);

        // Start pulses mid-load are ignored; start in DONE restarts.
        n0 = n_wr;
        cyc(1'b1, 9'd3, 1'b0, '0);
        for (int i = 0; i < 12; i++) cyc(i == 5, 9'd1, 1'b1, 8'(i));
        idle(2);
        chk("mid_nwr", 64'(n_wr - n0), 64'd3);
        chk("mid_last", 64'(last_addr), 64'd2);
        cyc(1'b1, 9'd1, 1'b0, '0);
        idle(1);
        chk("restart_done", 64'(done), 64'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 8'(i));
        idle(2);
        chk("restart_last", 64'(last_addr), 64'd0);

        // Random traffic, occasional resets and stray starts.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rstN       = ($urandom_range(0, 299) != 0);
            start      = ($urandom_range(0, 24) == 0);
            word_count = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511))
                                                      : 9'($urandom_range(0, 6));
            rx_valid   = ($urandom_range(0, 2) != 0);
            rx_data    = 8'($urandom);
        end
        rstN = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
